gray_code: RTL and testbench



---
 rtl/gray_code.sv | 87 ++++++++
 tb/tb_gray_code.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/gray_code.sv
`default_nettype none
// ============================================================================
//  Module      : gray_code
//  Description : 4-bit binary-to-Gray converter. F is a purely combinational
//                binary-to-Gray view of {A,B,C,D}. A registered sample path
//                converts in either direction (selected by mode) and flags
//                whether consecutive accepted samples differ by exactly one
//                bit in the Gray domain.
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_code (
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D,
    output logic [3:0] F,
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       mode,
    output logic [3:0] q,
    output logic       q_valid,
    output logic       step_ok
);

    localparam int unsigned C_WIDTH = 4;

    logic [C_WIDTH-1:0] w_in;
    logic [C_WIDTH-1:0] w_to_gray;
    logic [C_WIDTH-1:0] w_to_bin;
    logic [C_WIDTH-1:0] w_sample_g;
    logic [C_WIDTH-1:0] w_diff;
    logic               w_one_bit;

    logic [C_WIDTH-1:0] r_q;
    logic               r_q_valid;
    logic               r_step_ok;
    logic [C_WIDTH-1:0] r_prev_g;
    logic               r_have_prev;

    assign w_in = {A, B, C, D};

    // Binary-to-Gray: each Gray bit is the XOR of a binary bit and its upper neighbour.
    assign w_to_gray = w_in ^ {1'b0, w_in[C_WIDTH-1:1]};

    // Gray-to-binary: each binary bit accumulates the XOR of all Gray bits above it.
    always_comb begin
        w_to_bin = '0;
        w_to_bin[C_WIDTH-1] = w_in[C_WIDTH-1];
        for (int i = C_WIDTH - 2; i >= 0; i--) begin
            w_to_bin[i] = w_to_bin[i+1] ^ w_in[i];
        end
    end

    // Adjacency is always judged in the Gray domain, whichever way we convert.
    assign w_sample_g = mode ? w_in : w_to_gray;
    assign w_diff     = w_sample_g ^ r_prev_g;
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign w_one_bit  = (w_diff != '0) && ((w_diff & (w_diff - 1'b1)) == '0);

    assign F       = w_to_gray;
    assign q       = r_q;
    assign q_valid = r_q_valid;
    assign step_ok = r_step_ok;

    // Sample register: accept on in_valid, pulse-style valid/step flags otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q         <= '0;
            r_q_valid   <= 1'b0;
            r_step_ok   <= 1'b0;
            r_prev_g    <= '0;
            r_have_prev <= 1'b0;
        end else if (in_valid) begin
            r_q         <= mode ? w_to_bin : w_to_gray;
            r_q_valid   <= 1'b1;
            r_step_ok   <= r_have_prev & w_one_bit;
            r_prev_g    <= w_sample_g;
            r_have_prev <= 1'b1;
        end else begin
            r_q_valid   <= 1'b0;
            r_step_ok   <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gray_code.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gray_code
//  Description : Randomized scoreboard bench for gray_code. A reference model
//                pushes the expected registered outputs on every clock edge;
//                a monitor pops and compares them on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_code;

    typedef struct packed {
        logic [3:0] q;
        logic       qv;
        logic       so;
    } exp_t;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       mode = 1'b0;
    logic       A = 1'b0, B = 1'b0, C = 1'b0, D = 1'b0;
    logic [3:0] F;
    logic [3:0] q;
    logic       q_valid;
    logic       step_ok;

    int checks = 0;
    int failures = 0;

    exp_t exp_q[$];

    // Reference model state
    logic [3:0] m_prev_g = 4'd0;
    logic       m_have   = 1'b0;
    logic [3:0] m_q      = 4'd0;

    gray_code dut (
        .A(A), .B(B), .C(C), .D(D), .F(F),
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode),
        .q(q), .q_valid(q_valid), .step_ok(step_ok)
    );

    always #5 clk = clk_en ? ~clk : 1'b0;

    function automatic logic [3:0] gray_of(input int n);
        int g;
        g = n ^ (n >> 1);
        return g[3:0];
    endfunction

    // Inverse found by searching the forward table, not by a bit-serial XOR chain.
    function automatic logic [3:0] bin_of_gray(input logic [3:0] g);
        logic [3:0] r;
        r = 4'd0;
        for (int j = 0; j < 16; j++) begin
            if (gray_of(j) == g) r = j[3:0];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: one expected output triple per rising edge.
    always @(posedge clk) begin
        exp_t e;
        logic [3:0] n, gs;
        n = {A, B, C, D};
        if (!rst_n) begin
            m_q = 4'd0; m_prev_g = 4'd0; m_have = 1'b0;
            e.q = 4'd0; e.qv = 1'b0; e.so = 1'b0;
        end else if (in_valid) begin
            gs   = mode ? n : gray_of(int'(n));
            m_q  = mode ? bin_of_gray(n) : gray_of(int'(n));
            e.so = m_have && ($countones(gs ^ m_prev_g) == 1);
            e.qv = 1'b1;
            e.q  = m_q;
            m_prev_g = gs;
            m_have   = 1'b1;
        end else begin
            e.q = m_q; e.qv = 1'b0; e.so = 1'b0;
        end
        exp_q.push_back(e);
    end

    // Monitor: compare DUT registered outputs against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (clk_en) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("q", {28'd0, q}, {28'd0, e.q});
                check("q_valid", {31'd0, q_valid}, {31'd0, e.qv});
                check("step_ok", {31'd0, step_ok}, {31'd0, e.so});
            end
        end
    end

    // Drive one cycle of stimulus, check F combinationally, then step a clock.
    task automatic drive(input logic r, input logic v, input logic m, input logic [3:0] val);
        rst_n = r; in_valid = v; mode = m;
        {A, B, C, D} = val;
        #4;
        check("F", {28'd0, F}, {28'd0, gray_of(int'(val))});
        @(posedge clk);
        #2;
    endtask

    task automatic comb_check(input logic [3:0] val, input logic [3:0] req);
        {A, B, C, D} = val;
        #5;
        check("F_comb", {28'd0, F}, {28'd0, req});
    endtask

    initial begin
        // Combinational path with the clock held still
        comb_check(4'b0101, 4'b0111);
        comb_check(4'b0000, 4'b0000);
        comb_check(4'b1111, 4'b1000);
        comb_check(4'b1010, 4'b1111);
        for (int i = 0; i < 16; i++) comb_check(i[3:0], gray_of(i));

        // Start the clock in reset
        clk_en = 1'b1;
        @(posedge clk); #2;
        drive(1'b0, 1'b0, 1'b0, 4'b0000);

        // Directed sequence
        drive(1'b1, 1'b1, 1'b0, 4'b0101);   // q=0111, first sample: step_ok=0
        drive(1'b1, 1'b1, 1'b1, 4'b0111);   // Gray->bin: q=0101
        drive(1'b1, 1'b1, 1'b1, 4'b1000);   // q=1111
        drive(1'b1, 1'b1, 1'b0, 4'b0111);   // Gray 0100
        drive(1'b1, 1'b1, 1'b0, 4'b1000);   // Gray 1100: step_ok=1
        drive(1'b1, 1'b1, 1'b0, 4'b1010);   // Gray 1111: step_ok=0
        drive(1'b1, 1'b0, 1'b0, 4'b0011);   // gap: q holds, q_valid=0
        drive(1'b1, 1'b1, 1'b1, 4'b1111);   // identical Gray sample: step_ok=0
        drive(1'b0, 1'b1, 1'b0, 4'b0110);   // mid-stream reset
        drive(1'b1, 1'b1, 1'b1, 4'b0000);   // first after reset: step_ok=0
        drive(1'b1, 1'b1, 1'b1, 4'b1000);   // wrap-around Gray 1000 after 0000: step_ok=1

        // Randomized traffic, biased towards Gray-adjacent steps
        for (int k = 0; k < 400; k++) begin
            logic r, v, m;
            logic [3:0] val;
            r = ($urandom_range(0, 39) != 0);
            v = ($urandom_range(0, 3) != 0);
            m = $urandom_range(0, 1);
            val = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) != 0) begin
                logic [3:0] g;
                g = m_prev_g ^ (4'd1 << $urandom_range(0, 3));
                val = m ? g : bin_of_gray(g);
            end
            drive(r, v, m, val);
        end

        drive(1'b1, 1'b0, 1'b0, 4'b0000);
        @(negedge clk);
        #1;
        check("sb_drain", exp_q.size() <= 1 ? 32'd1 : 32'd0, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
